// File: rtl/sys_cmd_ctrl.sv
// Framed UART command parser: drives RF writes/reads and ALU ops, and streams responses into the TX FIFO.
// Optional inter-byte frame timeout is built when CMD_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | waiting for a command byte
// S_WR_ADDR  | RF_WR: waiting for address byte
// S_WR_DATA  | RF_WR: waiting for data byte
// S_RD_ADDR  | RF_RD: waiting for address byte
// S_RD_WAIT  | RF_RD: waiting for RF read data
// S_OP_A     | ALU_OP: waiting for operand A (written to RF[0])
// S_OP_B     | ALU_OP: waiting for operand B (written to RF[1])
// S_FUNC     | ALU_OP/ALU_NOP: waiting for function byte
// S_ALU_WAIT | ALU clock enabled, waiting for result
// S_TX       | pushing response bytes, LSB byte first
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     rx_data_i,
  input  logic                      rx_data_valid_i,
  output logic [ADDR_WIDTH-1:0]     rf_addr_o,
  output logic                      rf_wr_en_o,
  output logic [DATA_WIDTH-1:0]     rf_wr_data_o,
  output logic                      rf_rd_en_o,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data_i,
  input  logic                      rf_rd_valid_i,
  output logic [ALU_FUNC_WIDTH-1:0] alu_func_o,
  output logic                      alu_en_o,
  output logic                      alu_clk_en_o,
  input  logic [ALU_OUT_WIDTH-1:0]  alu_out_i,
  input  logic                      alu_out_valid_i,
  output logic                      fifo_wr_inc_o,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data_o,
  input  logic                      fifo_full_i,
  output logic                      busy_o,
  output logic                      cmd_error_o
);

  localparam int NB = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int CW = $clog2(NB + 1);

  localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = DATA_WIDTH'('hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = DATA_WIDTH'('hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'('hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'('hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_OP_A, S_OP_B, S_FUNC, S_ALU_WAIT, S_TX
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     rf_addr_q, rf_addr_d;
  logic                      rf_wr_en_q, rf_wr_en_d;
  logic [DATA_WIDTH-1:0]     rf_wr_data_q, rf_wr_data_d;
  logic                      rf_rd_en_q, rf_rd_en_d;
  logic [ALU_FUNC_WIDTH-1:0] alu_func_q, alu_func_d;
  logic                      alu_en_q, alu_en_d;
  logic                      alu_clk_en_q, alu_clk_en_d;
  logic                      cmd_error_q, cmd_error_d;
  logic [ALU_OUT_WIDTH-1:0]  tx_buf_q, tx_buf_d;
  logic [CW-1:0]             bcnt_q, bcnt_d;
  logic                      timeout_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmr_q, tmr_d;
  logic          in_frame;

  always_comb begin
    in_frame = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
               (state_q == S_RD_ADDR) || (state_q == S_OP_A)    ||
               (state_q == S_OP_B)    || (state_q == S_FUNC);
    tmr_d       = (in_frame && !rx_data_valid_i) ? tmr_q + TW'(1) : '0;
    timeout_hit = in_frame && !rx_data_valid_i && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_func_d   = alu_func_q;
    alu_clk_en_d = alu_clk_en_q;
    tx_buf_d     = tx_buf_q;
    bcnt_d       = bcnt_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    cmd_error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_data_valid_i) begin
          case (rx_data_i)
            CMD_RF_WR:   state_d = S_WR_ADDR;
            CMD_RF_RD:   state_d = S_RD_ADDR;
            CMD_ALU_OP:  state_d = S_OP_A;
            CMD_ALU_NOP: state_d = S_FUNC;
            default:     cmd_error_d = 1'b1;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (rx_data_valid_i) begin
          rf_addr_d = rx_data_i[ADDR_WIDTH-1:0];
          state_d   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (rx_data_valid_i) begin
          rf_wr_data_d = rx_data_i;
          rf_wr_en_d   = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (rx_data_valid_i) begin
          rf_addr_d  = rx_data_i[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        cmd_error_d = rx_data_valid_i;
        if (rf_rd_valid_i) begin
          tx_buf_d = ALU_OUT_WIDTH'(rf_rd_data_i);
          bcnt_d   = CW'(1);
          state_d  = S_TX;
        end
      end
      // ALU operands are staged through RF[0] / RF[1]
      S_OP_A: begin
        if (rx_data_valid_i) begin
          rf_addr_d    = '0;
          rf_wr_data_d = rx_data_i;
          rf_wr_en_d   = 1'b1;
          state_d      = S_OP_B;
        end
      end
      S_OP_B: begin
        if (rx_data_valid_i) begin
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = rx_data_i;
          rf_wr_en_d   = 1'b1;
          state_d      = S_FUNC;
        end
      end
      S_FUNC: begin
        if (rx_data_valid_i) begin
          alu_func_d   = rx_data_i[ALU_FUNC_WIDTH-1:0];
          alu_en_d     = 1'b1;
          alu_clk_en_d = 1'b1;
          state_d      = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        cmd_error_d = rx_data_valid_i;
        if (alu_out_valid_i) begin
          tx_buf_d     = alu_out_i;
          bcnt_d       = CW'(NB);
          alu_clk_en_d = 1'b0;
          state_d      = S_TX;
        end
      end
      S_TX: begin
        cmd_error_d = rx_data_valid_i;
        if (!fifo_full_i) begin
          tx_buf_d = tx_buf_q >> DATA_WIDTH;
          bcnt_d   = bcnt_q - CW'(1);
          if (bcnt_q == CW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // only asserted while a byte-wait state sees no byte, so no strobe is pending here
    if (timeout_hit) begin
      state_d     = S_IDLE;
      cmd_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      rf_rd_en_q   <= 1'b0;
      alu_func_q   <= '0;
      alu_en_q     <= 1'b0;
      alu_clk_en_q <= 1'b0;
      cmd_error_q  <= 1'b0;
      tx_buf_q     <= '0;
      bcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_func_q   <= alu_func_d;
      alu_en_q     <= alu_en_d;
      alu_clk_en_q <= alu_clk_en_d;
      cmd_error_q  <= cmd_error_d;
      tx_buf_q     <= tx_buf_d;
      bcnt_q       <= bcnt_d;
    end
  end

  assign rf_addr_o      = rf_addr_q;
  assign rf_wr_en_o     = rf_wr_en_q;
  assign rf_wr_data_o   = rf_wr_data_q;
  assign rf_rd_en_o     = rf_rd_en_q;
  assign alu_func_o     = alu_func_q;
  assign alu_en_o       = alu_en_q;
  assign alu_clk_en_o   = alu_clk_en_q;
  assign cmd_error_o    = cmd_error_q;
  assign busy_o         = (state_q != S_IDLE);
  // push is gated combinationally so a full FIFO never sees an increment
  assign fifo_wr_inc_o  = (state_q == S_TX) && !fifo_full_i;
  assign fifo_wr_data_o = tx_buf_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl: command-level reference model, RF/ALU responders and an output monitor.
module tb_sys_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic [3:0]  alu_func;
  logic        alu_en;
  logic        alu_clk_en;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        fifo_wr_inc;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic        cmd_error;

  always #5 clk = ~clk;

  sys_cmd_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUNC_WIDTH(4),
    .ALU_OUT_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_data_valid_i(rx_valid),
    .rf_addr_o(rf_addr), .rf_wr_en_o(rf_wr_en), .rf_wr_data_o(rf_wr_data),
    .rf_rd_en_o(rf_rd_en), .rf_rd_data_i(rf_rd_data), .rf_rd_valid_i(rf_rd_valid),
    .alu_func_o(alu_func), .alu_en_o(alu_en), .alu_clk_en_o(alu_clk_en),
    .alu_out_i(alu_out), .alu_out_valid_i(alu_out_valid),
    .fifo_wr_inc_o(fifo_wr_inc), .fifo_wr_data_o(fifo_wr_data), .fifo_full_i(fifo_full),
    .busy_o(busy), .cmd_error_o(cmd_error)
  );

  int checks = 0;
  int failures = 0;
  int err_exp = 0;
  int err_obs = 0;
  int gap_max = 0;
  bit ff_rand = 1'b0;

  logic [11:0] q_wr[$];
  logic [3:0]  q_rd[$];
  logic [3:0]  q_alu[$];
  logic [7:0]  q_push[$];
  logic [7:0]  ref_mem[16];
  logic [7:0]  stub_mem[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f[1:0])
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction

  // monitor: every DUT strobe is matched against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wr_en) begin
        stub_mem[rf_addr] = rf_wr_data;
        if (q_wr.size() == 0) unexpected("rf_wr");
        else chk("rf_wr", {20'h0, rf_addr, rf_wr_data}, {20'h0, q_wr.pop_front()});
      end
      if (rf_rd_en) begin
        if (q_rd.size() == 0) unexpected("rf_rd");
        else chk("rf_rd_addr", {28'h0, rf_addr}, {28'h0, q_rd.pop_front()});
      end
      if (alu_en) begin
        chk("alu_clk_en_at_en", {31'h0, alu_clk_en}, 32'h1);
        if (q_alu.size() == 0) unexpected("alu_en");
        else chk("alu_func", {28'h0, alu_func}, {28'h0, q_alu.pop_front()});
      end
      if (fifo_wr_inc) begin
        chk("push_while_full", {31'h0, fifo_full}, 32'h0);
        if (q_push.size() == 0) unexpected("fifo_push");
        else chk("fifo_data", {24'h0, fifo_wr_data}, {24'h0, q_push.pop_front()});
      end
      if (cmd_error) err_obs++;
    end
  end

  // RF read responder
  initial begin
    logic [3:0] a;
    rf_rd_valid = 1'b0;
    rf_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rf_rd_en === 1'b1 && !rst) begin
        a = rf_addr;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 rf_rd_data = stub_mem[a];
        rf_rd_valid = 1'b1;
        @(posedge clk);
        #1 rf_rd_valid = 1'b0;
        rf_rd_data = 8'($urandom);
      end
    end
  end

  // ALU responder, operands taken from what the DUT wrote into RF[0]/RF[1]
  initial begin
    logic [15:0] r;
    alu_out_valid = 1'b0;
    alu_out       = 16'h0;
    forever begin
      @(negedge clk);
      if (alu_en === 1'b1 && !rst) begin
        r = alu_f(stub_mem[0], stub_mem[1], alu_func);
        repeat ($urandom_range(3, 8)) @(posedge clk);
        #1 alu_out = r;
        alu_out_valid = 1'b1;
        @(posedge clk);
        #1 alu_out_valid = 1'b0;
        alu_out = 16'($urandom);
      end
    end
  end

  always @(posedge clk) begin
    if (ff_rand) #1 fifo_full = ($urandom_range(0, 2) == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_data = 8'($urandom);
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [7:0] d);
    ref_mem[a] = d;
    q_wr.push_back({a, d});
    send(8'hAA); send({4'h0, a}); send(d);
  endtask

  task automatic do_rd(input logic [3:0] a);
    q_rd.push_back(a);
    q_push.push_back(ref_mem[a]);
    send(8'hBB); send({4'h0, a});
  endtask

  task automatic do_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    logic [15:0] r;
    ref_mem[0] = a;
    ref_mem[1] = b;
    q_wr.push_back({4'h0, a});
    q_wr.push_back({4'h1, b});
    q_alu.push_back(f[3:0]);
    r = alu_f(a, b, f[3:0]);
    q_push.push_back(r[7:0]);
    q_push.push_back(r[15:8]);
    send(8'hCC); send(a); send(b); send(f);
  endtask

  task automatic do_nop(input logic [7:0] f);
    logic [15:0] r;
    q_alu.push_back(f[3:0]);
    r = alu_f(ref_mem[0], ref_mem[1], f[3:0]);
    q_push.push_back(r[7:0]);
    q_push.push_back(r[15:8]);
    send(8'hDD); send(f);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("busy_clears", {31'h0, busy}, 32'h0);
    chk("alu_clk_en_idle", {31'h0, alu_clk_en}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = 8'h00;
      stub_mem[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy",      {31'h0, busy},        32'h0);
    chk("rst_rf_wr_en",  {31'h0, rf_wr_en},    32'h0);
    chk("rst_rf_rd_en",  {31'h0, rf_rd_en},    32'h0);
    chk("rst_alu_en",    {31'h0, alu_en},      32'h0);
    chk("rst_alu_clk",   {31'h0, alu_clk_en},  32'h0);
    chk("rst_fifo_inc",  {31'h0, fifo_wr_inc}, 32'h0);
    chk("rst_cmd_err",   {31'h0, cmd_error},   32'h0);
    chk("rst_rf_addr",   {28'h0, rf_addr},     32'h0);
    chk("rst_fifo_data", {24'h0, fifo_wr_data}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // basic RF write, RF read, ALU op
    do_wr(4'h5, 8'h3C);
    wait_idle();
    do_rd(4'h5);
    wait_idle();
    do_alu(8'h0A, 8'h03, 8'h02);
    wait_idle();

    // ALU result held back by a full FIFO
    fifo_full = 1'b1;
    do_alu(8'h0A, 8'h03, 8'h02);
    n = 0;
    while (!alu_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("alu_valid_seen", {31'h0, alu_out_valid}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("stall_no_push", {31'h0, fifo_wr_inc}, 32'h0);
      chk("stall_data",    {24'h0, fifo_wr_data}, 32'h1E);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    wait_idle();

    // unknown command in IDLE, stray byte during ALU_WAIT
    err_exp++;
    send(8'h77);
    wait_idle();
    do_nop(8'h02);
    err_exp++;
    send(8'h55);
    wait_idle();

    // inter-byte timeout
`ifdef CMD_TIMEOUT_EN
    err_exp++;
    send(8'hAA); send(8'h05);
    repeat (20) @(negedge clk);
    chk("timeout_busy", {31'h0, busy}, 32'h0);
`else
    send(8'hAA); send(8'h05);
    repeat (20) @(negedge clk);
    chk("no_timeout_busy", {31'h0, busy}, 32'h1);
    ref_mem[5] = 8'h77;
    q_wr.push_back({4'h5, 8'h77});
    send(8'h77);
    wait_idle();
`endif

    // async reset in ALU_WAIT
    do_alu(8'h11, 8'h22, 8'h01);
    void'(q_push.pop_back());
    void'(q_push.pop_back());
    @(negedge clk);
    chk("alu_clk_en_wait", {31'h0, alu_clk_en}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_alu_clk_en", {31'h0, alu_clk_en}, 32'h0);
    chk("arst_busy",       {31'h0, busy},       32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    err_exp++;
    send(8'h3C);
    wait_idle();

    // randomized frames with random back-pressure and byte gaps
    gap_max = 3;
    ff_rand = 1'b1;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 4))
        0: do_wr(4'($urandom), 8'($urandom));
        1: do_rd(4'($urandom));
        2: do_alu(8'($urandom), 8'($urandom), 8'($urandom));
        3: do_nop(8'($urandom));
        default: begin
          b = 8'($urandom);
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
          err_exp++;
          send(b);
        end
      endcase
      wait_idle();
    end
    ff_rand = 1'b0;
    @(posedge clk);
    #1 fifo_full = 1'b0;
    repeat (20) @(negedge clk);

    chk("q_wr_drained",   q_wr.size(),   0);
    chk("q_rd_drained",   q_rd.size(),   0);
    chk("q_alu_drained",  q_alu.size(),  0);
    chk("q_push_drained", q_push.size(), 0);
    chk("cmd_error_count", err_obs, err_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
